// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - state, opcode, immediate, ALU and mux encodings for the multicycle RV32I controller
// Package riscv_ctrl_pkg (no ports). ILLEGAL_TRAP_EN adds state S_ILLEGAL.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR1    = 4'd10,
    S_JALR2    = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13
`ifdef ILLEGAL_TRAP_EN
    ,S_ILLEGAL = 4'd14
`endif
  } state_e;

  // Which ALU operation family the current state wants from the decoder.
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2,
    CLS_BR  = 2'd3
  } alu_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_src_f(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_JALR, OP_IMM: imm_src_f = IMM_I;
      OP_STORE:                 imm_src_f = IMM_S;
      OP_BRANCH:                imm_src_f = IMM_B;
      OP_JAL:                   imm_src_f = IMM_J;
      OP_LUI, OP_AUIPC:         imm_src_f = IMM_U;
      default:                  imm_src_f = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction-field, ALU-flag and control-output bundle of the controller
// master: drives op/funct3/funct7b5/Zero/LT/LTU, receives the control outputs.
// slave:  the controller side. ILLEGAL_TRAP_EN adds output illegal.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       LT;
  logic       LTU;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
`ifdef ILLEGAL_TRAP_EN
    input  illegal,
`endif
    output op, funct3, funct7b5, Zero, LT, LTU,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );

  modport slave (
`ifdef ILLEGAL_TRAP_EN
    output illegal,
`endif
    input  op, funct3, funct7b5, Zero, LT, LTU,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - combinational ALUControl decode from state class and funct fields
// Ports: alu_class (in), funct3 (in 3), funct7b5 (in), alu_control (out 4).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLS_R, CLS_I: begin
        case (funct3)
          // Immediates have no SUB: bit 30 is part of the immediate for ADDI.
          3'b000:  alu_control = (alu_class == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      CLS_BR: begin
        case (funct3[2:1])
          2'b00:   alu_control = ALU_SUB;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multicycle RV32I core
// Ports: clk, reset (sync, active-high), bus (multicycle_controller_if.slave).
// Optional ILLEGAL_TRAP_EN: unknown opcodes park in S_ILLEGAL with bus.illegal = 1.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.slave bus
);

  state_e     state_q, state_d;
  alu_class_e alu_class;
  logic [3:0] alu_control;
  logic       taken;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;

  alu_decoder u_alu_decoder (
    .alu_class  (alu_class),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .alu_control(alu_control)
  );

  always_comb begin
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.LT;
      3'b101:  taken = !bus.LT;
      3'b110:  taken = bus.LTU;
      3'b111:  taken = !bus.LTU;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_class  = CLS_ADD;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1; pc_write = 1'b1;
        alu_src_b = SRCB_FOUR; result_src = RES_ALURESULT;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch/JAL target is computed here while the opcode is decoded.
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_ILLEGAL;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM;
        state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD:  begin adr_src = 1'b1; state_d = S_MEMWB; end
      S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; state_d = S_FETCH; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; state_d = S_FETCH; end
      S_EXECR: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_RS2; alu_class = CLS_R;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; alu_class = CLS_I;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin reg_write = 1'b1; state_d = S_FETCH; end
      S_JAL, S_JALR2: begin
        // PC takes the target held in ALUOut; ALU meanwhile forms the link value.
        pc_write = 1'b1; alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR;
        state_d = S_ALUWB;
      end
      S_JALR1: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_RS2; alu_class = CLS_BR;
        pc_write = taken;
        state_d = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO; alu_src_b = SRCB_IMM;
        state_d = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`endif
      default: state_d = S_FETCH;
    endcase
    // Reset abandons the instruction: no architectural write at the coming edge.
    if (reset) begin
      pc_write = 1'b0; mem_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src_f(bus.op);
  assign bus.ALUControl = alu_control;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal    = !reset && (state_q == S_ILLEGAL);
`endif

endmodule
